l1d_entry_alloc: RTL and testbench

- Entry allocator for the L1D miss/fill entry array (ENTRY_NUM entries).
- Tracks a busy bit per entry and picks a free entry round-robin on each request.
- Produces a binary enable+index pair (alloc_en, alloc_idx) that feeds the per-entry one-hot enable decoder directly downstream.
- Also accepts entry releases and reports occupancy, full/empty and a sticky protocol-error flag.

---
 rtl/l1d_entry_alloc.sv | 172 +++++++++++++++++
 tb/tb_l1d_entry_alloc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_entry_alloc.sv
// l1d_entry_alloc
//
// Entry allocator for the L1D miss/fill entry array. Keeps one busy bit per
// entry and grants a free entry round-robin, starting the search at the entry
// after the one granted last. The grant is a binary enable+index pair that
// feeds the per-entry one-hot enable decoder directly downstream. Entries are
// returned through the free port. Occupancy, full/empty and a sticky
// bad-free flag are reported from registered state.
//
// Optional feature (compile-time macro L1D_ENTRY_ALLOC_FREE_BYPASS_EN):
//   When defined, an entry released this cycle is also searchable this cycle,
//   so a free and a re-allocation of the same entry can happen together. In
//   that case the busy bit stays set and busy_cnt is unchanged. When the macro
//   is undefined, a freed entry becomes grantable only from the next cycle.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-high reset
//   alloc_vld    in   requester wants one entry this cycle
//   alloc_rdy    out  a grantable entry exists this cycle
//   alloc_en     out  alloc_vld & alloc_rdy, allocation happens this cycle
//   alloc_idx    out  granted index (0 when alloc_rdy is low)
//   free_en      in   release one entry this cycle
//   free_idx     in   index being released
//   entry_busy   out  registered busy vector
//   busy_cnt     out  registered number of busy entries, 0..ENTRY_NUM
//   full         out  registered, busy_cnt == ENTRY_NUM
//   empty        out  registered, busy_cnt == 0
//   err_bad_free out  sticky, set by a free of a non-busy entry

module l1d_entry_alloc #(
    parameter int unsigned IDX_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_vld,
    output logic                       alloc_rdy,
    output logic                       alloc_en,
    output logic [IDX_WIDTH-1:0]       alloc_idx,
    input  logic                       free_en,
    input  logic [IDX_WIDTH-1:0]       free_idx,
    output logic [(1<<IDX_WIDTH)-1:0]  entry_busy,
    output logic [IDX_WIDTH:0]         busy_cnt,
    output logic                       full,
    output logic                       empty,
    output logic                       err_bad_free
);

    localparam int unsigned ENTRY_NUM = 1 << IDX_WIDTH;

    localparam logic [IDX_WIDTH:0]   CntOne  = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH:0]   CntZero = '0;
    localparam logic [IDX_WIDTH:0]   CntFull = (IDX_WIDTH+1)'(ENTRY_NUM);
    localparam logic [IDX_WIDTH-1:0] IdxOne  = IDX_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ENTRY_NUM-1:0] busy_q,   busy_d;
    logic [IDX_WIDTH:0]   cnt_q,    cnt_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 full_q,   full_d;
    logic                 empty_q,  empty_d;
    logic                 err_q,    err_d;

    // ------------------------------------------------------------------
    // Free classification
    // ------------------------------------------------------------------
    logic free_legal;
    logic free_bad;

    assign free_legal = free_en &  busy_q[free_idx];
    assign free_bad   = free_en & ~busy_q[free_idx];

    // ------------------------------------------------------------------
    // Search vector
    // ------------------------------------------------------------------
    logic [ENTRY_NUM-1:0] search_vec;

`ifdef L1D_ENTRY_ALLOC_FREE_BYPASS_EN
    logic [ENTRY_NUM-1:0] free_onehot;

    assign free_onehot = {{(ENTRY_NUM-1){1'b0}}, 1'b1} << free_idx;
    // A legally freed entry is offered to the requester in the same cycle.
    assign search_vec  = ~busy_q | (free_legal ? free_onehot : '0);
`else
    assign search_vec  = ~busy_q;
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: first set bit at or above rr_ptr, wrapping.
    // The loop runs from the farthest offset down to offset 0 so that the
    // last hit written is the one closest to rr_ptr, which avoids a break.
    // ------------------------------------------------------------------
    logic                 grant_found;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            // Index arithmetic wraps naturally at IDX_WIDTH bits.
            cand = rr_ptr_q + IDX_WIDTH'(i);
            if (search_vec[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign alloc_rdy = grant_found;
    assign alloc_en  = alloc_vld & grant_found;
    assign alloc_idx = grant_idx;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        // Clear before set: a bypassed free + re-alloc of one entry leaves it busy.
        if (free_legal) begin
            busy_d[free_idx] = 1'b0;
        end
        if (alloc_en) begin
            busy_d[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({alloc_en, free_legal})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase
    end

    assign rr_ptr_d = alloc_en ? (grant_idx + IdxOne) : rr_ptr_q;
    assign full_d   = (cnt_d == CntFull);
    assign empty_d  = (cnt_d == CntZero);
    assign err_d    = err_q | free_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign entry_busy   = busy_q;
    assign busy_cnt     = cnt_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign err_bad_free = err_q;

endmodule

// File: tb/tb_l1d_entry_alloc.sv
// Directed bench for l1d_entry_alloc (IDX_WIDTH = 4, 16 entries).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next rising edge.

module tb_l1d_entry_alloc;

    localparam int IW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_vld = 1'b0;
    logic          alloc_rdy;
    logic          alloc_en;
    logic [IW-1:0] alloc_idx;
    logic          free_en = 1'b0;
    logic [IW-1:0] free_idx = '0;
    logic [N-1:0]  entry_busy;
    logic [IW:0]   busy_cnt;
    logic          full;
    logic          empty;
    logic          err_bad_free;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1d_entry_alloc #(
        .IDX_WIDTH (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_vld    (alloc_vld),
        .alloc_rdy    (alloc_rdy),
        .alloc_en     (alloc_en),
        .alloc_idx    (alloc_idx),
        .free_en      (free_en),
        .free_idx     (free_idx),
        .entry_busy   (entry_busy),
        .busy_cnt     (busy_cnt),
        .full         (full),
        .empty        (empty),
        .err_bad_free (err_bad_free)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] busy, input logic [31:0] cnt,
                               input logic [31:0] f, input logic [31:0] e);
        check({tag, ".busy"},  32'(entry_busy), busy);
        check({tag, ".cnt"},   32'(busy_cnt),   cnt);
        check({tag, ".full"},  32'(full),       f);
        check({tag, ".empty"}, 32'(empty),      e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_vld = 1'b0;
        free_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        step();
        check_state("rst", 32'h0, 32'd0, 32'd0, 32'd1);
        check("rst.err",  32'(err_bad_free), 32'd0);
        check("rst.rdy",  32'(alloc_rdy),    32'd1);
        check("rst.idx",  32'(alloc_idx),    32'd0);
        rst = 1'b0;
        #1;

        // ---------------- three allocs: 0,1,2 ----------------
        alloc_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("a3.en%0d", i),  32'(alloc_en),  32'd1);
            check($sformatf("a3.idx%0d", i), 32'(alloc_idx), i);
            step();
        end
        alloc_vld = 1'b0;
        #1;
        check_state("a3", 32'h0007, 32'd3, 32'd0, 32'd0);
        check("a3.idle_en",  32'(alloc_en),  32'd0);
        check("a3.idle_idx", 32'(alloc_idx), 32'd3);  // rr_ptr = 3

        // ---------------- free 1 + alloc same cycle ----------------
        free_en = 1'b1; free_idx = 4'd1; alloc_vld = 1'b1;
        #1;
        check("fa.idx", 32'(alloc_idx), 32'd3);
        check("fa.en",  32'(alloc_en),  32'd1);
        step();
        free_en = 1'b0; alloc_vld = 1'b0;
        #1;
        check_state("fa", 32'h000D, 32'd3, 32'd0, 32'd0);
        check("fa.err",      32'(err_bad_free), 32'd0);
        check("fa.next_idx", 32'(alloc_idx),    32'd4);

        // ---------------- four more allocs then async reset ----------------
        alloc_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("b4.idx%0d", i), 32'(alloc_idx), 4 + i);
            step();
        end
        #1;
        check_state("b4", 32'h00FD, 32'd7, 32'd0, 32'd0);
        // Burst still active; reset lands mid-cycle, no clock edge before the check.
        rst = 1'b1;
        #1;
        check_state("arst", 32'h0, 32'd0, 32'd0, 32'd1);
        check("arst.idx", 32'(alloc_idx), 32'd0);
        alloc_vld = 1'b0;
        step();
        rst = 1'b0;
        alloc_vld = 1'b1;
        #1;
        check("arst.first_idx", 32'(alloc_idx), 32'd0);
        check("arst.first_en",  32'(alloc_en),  32'd1);
        alloc_vld = 1'b0;

        // ---------------- fill all 16 ----------------
        do_reset();
        alloc_vld = 1'b1;
        for (int i = 0; i < N; i++) begin
            #1;
            check($sformatf("fill.idx%0d", i), 32'(alloc_idx), i);
            step();
        end
        #1;
        check_state("full", 32'hFFFF, 32'd16, 32'd1, 32'd0);
        check("full.rdy", 32'(alloc_rdy), 32'd0);
        check("full.en",  32'(alloc_en),  32'd0);
        step();  // alloc_vld still high: nothing may change
        check_state("full.hold", 32'hFFFF, 32'd16, 32'd1, 32'd0);

        // Free 5 alone, then re-alloc; rr_ptr wrapped to 0.
        alloc_vld = 1'b0; free_en = 1'b1; free_idx = 4'd5;
        step();
        free_en = 1'b0;
        #1;
        check_state("f5", 32'hFFDF, 32'd15, 32'd0, 32'd0);
        alloc_vld = 1'b1;
        #1;
        check("f5.idx", 32'(alloc_idx), 32'd5);
        step();
        alloc_vld = 1'b0;
        #1;
        check_state("f5.realloc", 32'hFFFF, 32'd16, 32'd1, 32'd0);

        // Free 5 and request in the same cycle while full.
        free_en = 1'b1; free_idx = 4'd5; alloc_vld = 1'b1;
        #1;
`ifdef L1D_ENTRY_ALLOC_FREE_BYPASS_EN
        check("byp.rdy", 32'(alloc_rdy), 32'd1);
        check("byp.idx", 32'(alloc_idx), 32'd5);
        step();
        free_en = 1'b0; alloc_vld = 1'b0;
        #1;
        check_state("byp", 32'hFFFF, 32'd16, 32'd1, 32'd0);
`else
        check("nobyp.rdy", 32'(alloc_rdy), 32'd0);
        check("nobyp.en",  32'(alloc_en),  32'd0);
        step();
        free_en = 1'b0; alloc_vld = 1'b0;
        #1;
        check_state("nobyp", 32'hFFDF, 32'd15, 32'd0, 32'd0);
`endif
        check("full.err", 32'(err_bad_free), 32'd0);

        // ---------------- illegal free ----------------
        do_reset();
        free_en = 1'b1; free_idx = 4'd9;
        step();
        free_en = 1'b0;
        #1;
        check_state("bad", 32'h0, 32'd0, 32'd0, 32'd1);
        check("bad.err", 32'(err_bad_free), 32'd1);
        alloc_vld = 1'b1;
        step();
        step();
        alloc_vld = 1'b0;
        #1;
        check("bad.sticky_err", 32'(err_bad_free), 32'd1);
        check("bad.sticky_cnt", 32'(busy_cnt),     32'd2);
        // Legal free now (entry 1 busy) must not disturb the flag.
        free_en = 1'b1; free_idx = 4'd1;
        step();
        free_en = 1'b0;
        #1;
        check_state("bad.legal", 32'h0001, 32'd1, 32'd0, 32'd0);
        check("bad.legal_err", 32'(err_bad_free), 32'd1);
        rst = 1'b1;
        #1;
        check("bad.clr_err", 32'(err_bad_free), 32'd0);
        step();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
